// File: rtl/fc_core_feeder.sv
// rtl/fc_core_feeder.sv - sequencer feeding node/weight pairs into one fully connected MAC core
module fc_core_feeder #(
    parameter int IN_DATA_WITDH = 16,
    parameter int ADDR_WIDTH    = 5
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_start,
    input  logic [ADDR_WIDTH:0]               i_num,
    output logic                              o_idle,
    output logic                              o_done,
    output logic                              o_node_ce,
    output logic                              o_wegt_ce,
    output logic [ADDR_WIDTH-1:0]             o_node_addr,
    output logic [ADDR_WIDTH-1:0]             o_wegt_addr,
    input  logic signed [IN_DATA_WITDH-1:0]   i_node_q,
    input  logic signed [IN_DATA_WITDH-1:0]   i_wegt_q,
    output logic                              o_core_run,
    output logic                              o_core_valid,
    output logic signed [IN_DATA_WITDH-1:0]   o_core_node,
    output logic signed [IN_DATA_WITDH-1:0]   o_core_wegt,
    input  logic                              i_core_valid,
    input  logic signed [4*IN_DATA_WITDH-1:0] i_core_result,
    output logic signed [4*IN_DATA_WITDH-1:0] o_result,
    output logic                              o_result_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_N   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                            state_q, state_d;
    logic [ADDR_WIDTH:0]               num_q;
    logic [ADDR_WIDTH:0]               rd_cnt_q;
    logic [ADDR_WIDTH:0]               ret_cnt_q;
    logic                              core_valid_q;
    logic signed [4*IN_DATA_WITDH-1:0] result_q;

    logic [ADDR_WIDTH:0] num_clamped;
    logic [ADDR_WIDTH:0] num_last;
    logic                rd_last;
    logic                in_rx;
    logic                capture;

    // Pair count is clamped to the memory depth; last index is only used when N > 0.
    assign num_clamped = (i_num > MAX_N) ? MAX_N : i_num;
    assign num_last    = num_q - CNT_ONE;
    assign rd_last     = (rd_cnt_q == num_last);
    assign in_rx       = (state_q == S_READ) || (state_q == S_WAIT);
    assign capture     = in_rx && i_core_valid && (ret_cnt_q == num_last);

    // Next-state logic; capture wins over the READ->WAIT step so an early last return is never lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RUN;
            S_RUN:   state_d = (num_q != '0) ? S_READ : S_DONE;
            S_READ: begin
                if (capture)      state_d = S_DONE;
                else if (rd_last) state_d = S_WAIT;
            end
            S_WAIT:  if (capture) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, the memory-latency-aligned core valid, and the captured result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            rd_cnt_q     <= '0;
            ret_cnt_q    <= '0;
            core_valid_q <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            core_valid_q <= (state_q == S_READ);
            if (state_q == S_IDLE && i_start) begin
                num_q <= num_clamped;
            end
            if (state_q == S_RUN) begin
                rd_cnt_q <= '0;
            end else if (state_q == S_READ) begin
                rd_cnt_q <= rd_cnt_q + CNT_ONE;
            end
            if (state_q == S_RUN) begin
                ret_cnt_q <= '0;
            end else if (in_rx && i_core_valid) begin
                ret_cnt_q <= ret_cnt_q + CNT_ONE;
            end
            if (capture) begin
                result_q <= i_core_result;
            end else if (state_q == S_RUN && num_q == '0) begin
                result_q <= '0;
            end
        end
    end

    assign o_idle         = (state_q == S_IDLE);
    assign o_done         = (state_q == S_DONE);
    assign o_result_valid = (state_q == S_DONE);
    assign o_core_run     = (state_q == S_RUN);
    assign o_node_ce      = (state_q == S_READ);
    assign o_wegt_ce      = (state_q == S_READ);
    assign o_node_addr    = rd_cnt_q[ADDR_WIDTH-1:0];
    assign o_wegt_addr    = rd_cnt_q[ADDR_WIDTH-1:0];
    assign o_core_valid   = core_valid_q;
    assign o_core_node    = i_node_q;
    assign o_core_wegt    = i_wegt_q;
    assign o_result       = result_q;

endmodule

// File: tb/tb_fc_core_feeder.sv
// tb/tb_fc_core_feeder.sv - directed table-driven bench for fc_core_feeder with memory and MAC core models
module tb_fc_core_feeder;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               i_start;
    logic [5:0]         i_num;
    logic               o_idle, o_done;
    logic               o_node_ce, o_wegt_ce;
    logic [4:0]         o_node_addr, o_wegt_addr;
    logic signed [15:0] i_node_q = '0;
    logic signed [15:0] i_wegt_q = '0;
    logic               o_core_run, o_core_valid;
    logic signed [15:0] o_core_node, o_core_wegt;
    logic               i_core_valid = 1'b0;
    logic signed [63:0] i_core_result = '0;
    logic signed [63:0] o_result;
    logic               o_result_valid;

    fc_core_feeder #(.IN_DATA_WITDH(16), .ADDR_WIDTH(5)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_num(i_num),
        .o_idle(o_idle), .o_done(o_done),
        .o_node_ce(o_node_ce), .o_wegt_ce(o_wegt_ce),
        .o_node_addr(o_node_addr), .o_wegt_addr(o_wegt_addr),
        .i_node_q(i_node_q), .i_wegt_q(i_wegt_q),
        .o_core_run(o_core_run), .o_core_valid(o_core_valid),
        .o_core_node(o_core_node), .o_core_wegt(o_core_wegt),
        .i_core_valid(i_core_valid), .i_core_result(i_core_result),
        .o_result(o_result), .o_result_valid(o_result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories and a MAC core whose output lags its valid input by one cycle.
    logic signed [15:0] node_mem [32];
    logic signed [15:0] wegt_mem [32];
    always @(posedge clk) begin
        if (o_node_ce) i_node_q <= node_mem[o_node_addr];
        if (o_wegt_ce) i_wegt_q <= wegt_mem[o_wegt_addr];
        i_core_valid <= o_core_valid;
        if (o_core_run) i_core_result <= '0;
        else if (o_core_valid)
            i_core_result <= i_core_result + longint'(o_core_node) * longint'(o_core_wegt);
    end

    typedef struct {
        int     num;
        int     kind;
        bit     extra;
        longint exp_res;
        int     exp_n;
    } vec_t;

    vec_t vecs[8];
    int passed = 0;
    int total  = 0;
    int start_cyc;
    int ce_count, cv_count, run_count, done_count, addr_err;
    int first_ce, last_addr, run_cyc, done_cyc;
    longint res_at_done;
    int rv_at_done;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < 32; i++) begin
            node_mem[i] = 16'sd100;
            wegt_mem[i] = 16'sd100;
        end
        case (kind)
            0: for (int i = 0; i < 4; i++) begin
                node_mem[i] = 16'(i + 1);
                wegt_mem[i] = 16'(i + 5);
            end
            1: for (int i = 0; i < 32; i++) begin
                node_mem[i] = -16'sd32768;
                wegt_mem[i] = -16'sd32768;
            end
            2: begin
                node_mem[0] = -16'sd3; node_mem[1] = 16'sd7;
                wegt_mem[0] = 16'sd4;  wegt_mem[1] = -16'sd2;
            end
            3: for (int i = 0; i < 32; i++) begin
                node_mem[i] = 16'sd1;
                wegt_mem[i] = 16'sd1;
            end
            default: begin
                node_mem[0] = 16'sd2;
                wegt_mem[0] = 16'sd3;
            end
        endcase
    endtask

    task automatic clear_stats();
        ce_count = 0; cv_count = 0; run_count = 0; done_count = 0; addr_err = 0;
        first_ce = -1; last_addr = -1; run_cyc = -1; done_cyc = -1;
        res_at_done = -1; rv_at_done = -1;
    endtask

    task automatic sample(input int rel);
        if (o_node_ce) begin
            if (int'(o_node_addr) != ce_count) addr_err++;
            if (ce_count == 0) first_ce = rel;
            last_addr = int'(o_node_addr);
            ce_count++;
        end
        if (o_node_ce !== o_wegt_ce || o_node_addr !== o_wegt_addr) addr_err++;
        if (o_core_valid) cv_count++;
        if (o_core_run) begin run_count++; run_cyc = rel; end
        if (o_done) begin
            done_count++;
            done_cyc    = rel;
            res_at_done = o_result;
            rv_at_done  = int'(o_result_valid);
        end
    endtask

    // Starts a job at the cycle after the previous call returned, so consecutive calls are back-to-back.
    task automatic run_job(input vec_t v, input int idx);
        int rel;
        bit got;
        fill(v.kind);
        clear_stats();
        @(posedge clk); #1;
        i_start   = 1'b1;
        i_num     = 6'(v.num);
        start_cyc = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_num   = 6'd3;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            rel = cyc - start_cyc;
            sample(rel);
            if (v.extra) i_start = (rel == 5 || rel == 20);
            if (done_count > 0) got = 1'b1;
        end
        i_start = 1'b0;
        chk($sformatf("v%0d done_seen", idx), longint'(got), 1);
        if (v.extra) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                sample(cyc - start_cyc);
            end
            chk($sformatf("v%0d idle_after", idx), longint'(o_idle), 1);
        end
        chk($sformatf("v%0d result", idx), res_at_done, v.exp_res);
        chk($sformatf("v%0d result_valid", idx), rv_at_done, 1);
        chk($sformatf("v%0d done_cycle", idx), done_cyc, (v.exp_n == 0) ? 2 : v.exp_n + 4);
        chk($sformatf("v%0d done_count", idx), done_count, 1);
        chk($sformatf("v%0d run_cycle", idx), run_cyc, 1);
        chk($sformatf("v%0d run_count", idx), run_count, 1);
        chk($sformatf("v%0d ce_count", idx), ce_count, v.exp_n);
        chk($sformatf("v%0d core_valid_count", idx), cv_count, v.exp_n);
        chk($sformatf("v%0d addr_errors", idx), addr_err, 0);
        chk($sformatf("v%0d first_ce", idx), first_ce, (v.exp_n == 0) ? -1 : 2);
        chk($sformatf("v%0d last_addr", idx), last_addr, v.exp_n - 1);
    endtask

    initial begin
        int rel;
        vecs[0] = '{num: 4,  kind: 0, extra: 1'b0, exp_res: 70,          exp_n: 4};
        vecs[1] = '{num: 2,  kind: 1, extra: 1'b0, exp_res: 64'd2147483648, exp_n: 2};
        vecs[2] = '{num: 2,  kind: 2, extra: 1'b0, exp_res: -26,         exp_n: 2};
        vecs[3] = '{num: 0,  kind: 0, extra: 1'b0, exp_res: 0,           exp_n: 0};
        vecs[4] = '{num: 32, kind: 3, extra: 1'b1, exp_res: 32,          exp_n: 32};
        vecs[5] = '{num: 4,  kind: 0, extra: 1'b0, exp_res: 70,          exp_n: 4};
        vecs[6] = '{num: 1,  kind: 4, extra: 1'b0, exp_res: 6,           exp_n: 1};
        vecs[7] = '{num: 40, kind: 3, extra: 1'b0, exp_res: 32,          exp_n: 32};

        reset_n = 1'b0;
        i_start = 1'b0;
        i_num   = '0;
        fill(0);
        repeat (3) @(negedge clk);
        chk("reset idle", longint'(o_idle), 1);
        chk("reset done", longint'(o_done), 0);
        chk("reset ce", longint'(o_node_ce | o_wegt_ce), 0);
        chk("reset run", longint'(o_core_run), 0);
        chk("reset result", o_result, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_job(vecs[i], i);

        // Reset in cycle 4 of an N=8 job, while the core valid is high.
        fill(3);
        @(posedge clk); #1;
        i_start   = 1'b1;
        i_num     = 6'd8;
        start_cyc = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        rel = 1;
        for (int k = 0; k < 20 && rel < 4; k++) begin
            @(negedge clk);
            rel = cyc - start_cyc;
        end
        chk("pre_reset core_valid", longint'(o_core_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset idle", longint'(o_idle), 1);
        chk("mid_reset core_valid", longint'(o_core_valid), 0);
        chk("mid_reset ce", longint'(o_node_ce | o_wegt_ce), 0);
        chk("mid_reset addr", longint'(o_node_addr), 0);
        chk("mid_reset result", o_result, 0);
        chk("mid_reset result_valid", longint'(o_result_valid), 0);
        repeat (2) @(negedge clk);
        chk("held_reset idle", longint'(o_idle), 1);
        reset_n = 1'b1;
        run_job(vecs[0], 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
